// File: rtl/pll_seq_pkg.sv
// Shared state encoding, default timing parameters and a small constant helper
// for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_STAGE_GAP_CYCLES    = 8;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int NUM_DOMAINS             = 4;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAULT
  } seq_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing a single asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a stable lock, then releases the output-clock
// domain resets one after another; retries a bounded number of times before faulting.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   retry_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   fault,
  output logic [1:0]             retry_count
);

  localparam int RELEASE_SPAN = (NUM_DOMAINS - 1) * STAGE_GAP_CYCLES;
  localparam int MAX_CYCLES   = max_of(max_of(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES),
                                       max_of(LOCK_STABLE_CYCLES, RELEASE_SPAN + 1));
  localparam int CNT_W        = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_SPAN);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  seq_state_t             state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [1:0]             retry_next;
  logic                   pll_rst_next, ready_next, fault_next;
  logic [NUM_DOMAINS-1:0] domain_next;
  logic                   locked_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Every counter path clears on its terminal count, so cnt never wraps.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    retry_next = retry_count;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_next = '0;
          if (retry_count == RETRY_LIMIT) begin
            state_next = FAULT;
          end else begin
            state_next = PLL_RST;
            retry_next = retry_count + 2'd1;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          state_next = PLL_RST;
          cnt_next   = '0;
          retry_next = 2'd0;
        end else if (cnt == RELEASE_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_next = PLL_RST;
          cnt_next   = '0;
          retry_next = 2'd0;
        end
      end
      FAULT: begin
        if (retry_req) begin
          state_next = PLL_RST;
          cnt_next   = '0;
          retry_next = 2'd0;
        end
      end
      default: begin
        state_next = PLL_RST;
        cnt_next   = '0;
        retry_next = 2'd0;
      end
    endcase

    // Outputs are decoded from the upcoming state so they land in flops alongside it.
    pll_rst_next = (state_next == PLL_RST);
    ready_next   = (state_next == RUN);
    fault_next   = (state_next == FAULT);
    domain_next  = '1;
    if (state_next == RUN) begin
      domain_next = '0;
    end else if (state_next == RELEASE) begin
      for (int k = 0; k < NUM_DOMAINS; k++) begin
        domain_next[k] = (cnt_next < CNT_W'(k * STAGE_GAP_CYCLES));
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= PLL_RST;
      cnt         <= '0;
      retry_count <= 2'd0;
      pll_rst     <= 1'b1;
      domain_rst  <= '1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      retry_count <= retry_next;
      pll_rst     <= pll_rst_next;
      domain_rst  <= domain_next;
      ready       <= ready_next;
      fault       <= fault_next;
    end
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16, PLL reset pulse length in refclk cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 50000, maximum wait for lock per attempt (1 ms at 50 MHz).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive locked cycles required before release.
REQ-004 SHALL have parameter STAGE_GAP_CYCLES, default 8, spacing between successive domain reset releases.
REQ-005 SHALL have parameter MAX_RETRIES, default 3, PLL re-reset attempts before fault.
REQ-006 SHALL have port refclk  in  1  sole clock, 50 MHz PLL reference.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port pll_locked  in  1  PLL lock indicator, asynchronous to refclk.
REQ-009 SHALL have port retry_req  in  1  single-cycle pulse, restarts sequencing from FAULT.
REQ-010 SHALL have port pll_rst  out  1  reset to PLL, active-high.
REQ-011 SHALL have port domain_rst  out  4  per-output-clock domain reset, active-high, bit k for outclk_k.
REQ-012 SHALL have port ready  out  1  all domains released, lock valid.
REQ-013 SHALL have port fault  out  1  lock not achieved within MAX_RETRIES retries.
REQ-014 SHALL have port retry_count  out  2  retries consumed in current sequence.

Function
REQ-015 SHALL pass pll_locked through a two-flop synchronizer (locked_s); all decisions use locked_s only.
REQ-016 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT; all outputs registered.
REQ-017 PLL_RST: pll_rst=1, domain_rst=4'hF, ready=0; after exactly RST_PULSE_CYCLES cycles -> WAIT_LOCK, counter cleared.
REQ-018 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE, counter cleared; LOCK_TIMEOUT_CYCLES elapsed without lock -> retry_count==MAX_RETRIES ? FAULT : (retry_count+1, PLL_RST).
REQ-019 STABLE: locked_s=0 before LOCK_STABLE_CYCLES consecutive cycles -> WAIT_LOCK with timeout counter restarted; count reached -> RELEASE.
REQ-020 RELEASE: domain_rst[0] cleared first RELEASE cycle, bit k cleared k*STAGE_GAP_CYCLES cycles later; cycle after bit 3 cleared -> RUN, ready=1.
REQ-021 RUN: hold domain_rst=4'h0, ready=1 while locked_s=1.
REQ-022 locked_s=0 in RELEASE or RUN SHALL set domain_rst=4'hF, ready=0 on next edge, clear retry_count, -> PLL_RST.
REQ-023 FAULT: fault=1, pll_rst=0, domain_rst=4'hF, ready=0; exit only via rst or retry_req (-> PLL_RST, retry_count=0, fault=0).
REQ-024 retry_req outside FAULT SHALL be ignored.
REQ-025 Counters SHALL be sized by $clog2 of the largest parameter +1 and SHALL never wrap.

Reset
REQ-026 rst=1 SHALL force on next edge: state PLL_RST, pll_rst=1, domain_rst=4'hF, ready=0, fault=0, retry_count=0, counters and synchronizer=0.
REQ-027 rst asserted mid-sequence SHALL abort immediately, including mid-RELEASE, re-asserting all domain resets.

Structure
REQ-028 State enum and parameter defaults SHALL reside in package pll_seq_pkg.
REQ-029 Synchronizer SHALL be sub-module sync_2ff (1-bit, refclk, sync reset to 0).
REQ-030 Domain resets are refclk-domain; each consumer domain SHALL re-synchronize its bit.

Verification (params 4/20/8/2/2)
REQ-031 rst then pll_locked=1 from cycle 6 -> pll_rst high 4 cycles; domain_rst bits clear at 2-cycle spacing after 8 stable cycles; ready=1, retry_count=0.
REQ-032 pll_locked held 0 -> 3 pll_rst pulses spaced 24 cycles, then fault=1, retry_count=2, domain_rst=4'hF.
REQ-033 pll_locked drops 1 cycle at STABLE count 5 -> return to WAIT_LOCK, no domain released, full 8-cycle count restarts.
REQ-034 In RUN, pll_locked falls -> domain_rst=4'hF and ready=0 within 3 cycles, new 4-cycle pll_rst pulse follows.
REQ-035 In FAULT, retry_req pulse -> fault=0, retry_count=0, pll_rst=1 next cycle; retry_req pulse in RUN -> no change.
REQ-036 rst asserted after domain_rst[0] released -> domain_rst=4'hF, state PLL_RST next edge.
